// File: rtl/timer_pkg.sv
// Shared register-map indices, CTRL bit positions and the CTRL record type
// used by the timer_bank slice.
package timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LIMIT  = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned CTRL_EN_BIT       = 0;
    localparam int unsigned CTRL_PERIODIC_BIT = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT   = 2;

    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic en;
    } timer_ctrl_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: up-counter with >= limit compare, one-shot/periodic
// reload and a sticky write-1-to-clear pending flag.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned RST_LIMIT = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ctrl_we,
    input  logic             limit_we,
    input  logic             count_we,
    input  logic             status_we,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] limit,
    output logic             pending,
    output timer_ctrl_t      ctrl
);

    logic fire;

    assign fire = tick && ctrl.en && (count >= limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl    <= '0;
            limit   <= CNT_W'(RST_LIMIT);
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (tick && ctrl.en) begin
                if (fire) begin
                    count <= '0;
                    if (!ctrl.periodic) begin
                        ctrl.en <= 1'b0;
                    end
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
            // Later assignments win: hardware set beats W1C, software writes beat tick updates.
            if (status_we && wdata[0]) begin
                pending <= 1'b0;
            end
            if (fire) begin
                pending <= 1'b1;
            end
            if (count_we) begin
                count <= wdata[CNT_W-1:0];
            end
            if (ctrl_we) begin
                ctrl.en       <= wdata[CTRL_EN_BIT];
                ctrl.periodic <= wdata[CTRL_PERIODIC_BIT];
                ctrl.irq_en   <= wdata[CTRL_IRQ_EN_BIT];
            end
            if (limit_we) begin
                limit <= wdata[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/timer_bank.sv
// NUM_CH-channel memory-mapped timer bank with per-channel and aggregated IRQs.
// Optional shared tick prescaler enabled by defining TIMER_PRESCALE_EN.
module timer_bank
    import timer_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned RST_LIMIT    = 10000,
    parameter int unsigned PRESCALE_DIV = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req,
    input  logic                        we,
    input  logic [$clog2(NUM_CH)+1:0]   addr,
    input  logic [31:0]                 wdata,
    output logic [31:0]                 rdata,
    output logic [NUM_CH-1:0]           timer_irq,
    output logic                        timer_interrupt
);

    localparam int unsigned AW = $clog2(NUM_CH) + 2;

    logic [4:0]       ch_idx;
    logic [1:0]       reg_sel;
    logic             tick;
    logic [31:0]      rd_val;
    logic [NUM_CH-1:0] ctrl_we, limit_we, count_we, status_we, pending;
    logic [CNT_W-1:0] count_a [NUM_CH];
    logic [CNT_W-1:0] limit_a [NUM_CH];
    timer_ctrl_t      ctrl_a  [NUM_CH];

    assign reg_sel = addr[1:0];

    if (AW > 2) begin : g_idx
        assign ch_idx = 5'(addr[AW-1:2]);
    end else begin : g_idx_single
        assign ch_idx = '0;
    end

`ifdef TIMER_PRESCALE_EN
    localparam int unsigned PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

    logic [PW-1:0] pre_cnt;

    assign tick = (pre_cnt == PW'(PRESCALE_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Indices that match no channel produce no strobe, so out-of-range writes vanish.
    always_comb begin
        ctrl_we   = '0;
        limit_we  = '0;
        count_we  = '0;
        status_we = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ctrl_we[i]   = req && we && (ch_idx == 5'(i)) && (reg_sel == REG_CTRL);
            limit_we[i]  = req && we && (ch_idx == 5'(i)) && (reg_sel == REG_LIMIT);
            count_we[i]  = req && we && (ch_idx == 5'(i)) && (reg_sel == REG_COUNT);
            status_we[i] = req && we && (ch_idx == 5'(i)) && (reg_sel == REG_STATUS);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_channel #(
            .CNT_W     (CNT_W),
            .RST_LIMIT (RST_LIMIT)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .ctrl_we   (ctrl_we[g]),
            .limit_we  (limit_we[g]),
            .count_we  (count_we[g]),
            .status_we (status_we[g]),
            .wdata     (wdata),
            .count     (count_a[g]),
            .limit     (limit_a[g]),
            .pending   (pending[g]),
            .ctrl      (ctrl_a[g])
        );
    end

    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_idx == 5'(i)) begin
                case (reg_sel)
                    REG_CTRL:   rd_val = {29'b0, ctrl_a[i]};
                    REG_LIMIT:  rd_val = 32'(limit_a[i]);
                    REG_COUNT:  rd_val = 32'(count_a[i]);
                    default:    rd_val = {31'b0, pending[i]};
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (req && !we) begin
            rdata <= rd_val;
        end
    end

    always_comb begin
        timer_irq = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            timer_irq[i] = pending[i] && ctrl_a[i].irq_en;
        end
    end

    assign timer_interrupt = |timer_irq;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank (3 channels so that channel index 3 is
// out of range); register reads are checked through an expected-value queue.
module tb_timer_bank;

`ifdef TIMER_PRESCALE_EN
    localparam int unsigned TB_DIV = 4;
`else
    localparam int unsigned TB_DIV = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [2:0]  timer_irq;
    logic        timer_interrupt;

    int unsigned total = 0;
    int unsigned bad = 0;
    logic        rd_seen = 1'b0;
    logic [31:0] exp_q [$];
    string       name_q [$];

    timer_bank #(
        .NUM_CH       (3),
        .CNT_W        (32),
        .RST_LIMIT    (10000),
        .PRESCALE_DIV (TB_DIV)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .we              (we),
        .addr            (addr),
        .wdata           (wdata),
        .rdata           (rdata),
        .timer_irq       (timer_irq),
        .timer_interrupt (timer_interrupt)
    );

    always #5 clk = ~clk;

    // Scoreboard: every read pushes its expected value; the result is popped one cycle later.
    always @(posedge clk) rd_seen <= req && !we;

    always @(negedge clk) begin
        if (rd_seen) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard: rdata=%h with no expected entry", rdata);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                automatic string n = name_q.pop_front();
                if (rdata !== e) begin
                    bad++;
                    $display("FAIL %s: rdata=%h expected %h", n, rdata, e);
                end
            end
        end
    end

    // All bus tasks start and end on a falling edge.
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
        req = 1'b1; we = 1'b0; addr = a;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        total++; if (timer_irq !== 3'b000) begin bad++; $display("FAIL rst_irq: got %b want 000", timer_irq); end
        total++; if (timer_interrupt !== 1'b0) begin bad++; $display("FAIL rst_int: got %b want 0", timer_interrupt); end
        rst = 1'b0;
        rd(4'd1, 32'd10000, "rst_lim0");
        rd(4'd2, 32'd0, "rst_cnt0");
        rd(4'd0, 32'd0, "rst_ctrl0");
        rd(4'd3, 32'd0, "rst_st0");
    endtask

    task automatic test_periodic;
        wr(4'd1, 32'd3);
        wr(4'd0, 32'b111);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (timer_irq[0] !== (k == 4) || timer_interrupt !== (k == 4)) begin
                bad++;
                $display("FAIL periodic_first k=%0d: irq0=%b int=%b want %b", k, timer_irq[0], timer_interrupt, k == 4);
            end
        end
        wr(4'd3, 32'd1);
        total++; if (timer_irq[0] !== 1'b0) begin bad++; $display("FAIL periodic_w1c: irq0=%b want 0", timer_irq[0]); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++;
            if (timer_irq[0] !== (k == 3) || timer_interrupt !== (k == 3)) begin
                bad++;
                $display("FAIL periodic_second k=%0d: irq0=%b int=%b want %b", k, timer_irq[0], timer_interrupt, k == 3);
            end
        end
        rd(4'd3, 32'd1, "periodic_status");
        wr(4'd0, 32'd0);
        wr(4'd3, 32'd1);
        total++; if (timer_interrupt !== 1'b0) begin bad++; $display("FAIL periodic_stop: int=%b want 0", timer_interrupt); end
    endtask

    task automatic test_oneshot;
        wr(4'd5, 32'd2);
        wr(4'd4, 32'b101);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++;
            if (timer_irq[1] !== (k == 3)) begin
                bad++;
                $display("FAIL oneshot_fire k=%0d: irq1=%b want %b", k, timer_irq[1], k == 3);
            end
        end
        rd(4'd4, 32'd4, "oneshot_ctrl");
        rd(4'd6, 32'd0, "oneshot_cnt");
        repeat (3) @(negedge clk);
        rd(4'd6, 32'd0, "oneshot_cnt_hold");
        rd(4'd7, 32'd1, "oneshot_status");
        total++; if (timer_irq[1] !== 1'b1) begin bad++; $display("FAIL oneshot_level: irq1=%b want 1", timer_irq[1]); end
        wr(4'd7, 32'd1);
        total++; if (timer_irq[1] !== 1'b0) begin bad++; $display("FAIL oneshot_clear: irq1=%b want 0", timer_irq[1]); end
        wr(4'd4, 32'd0);
    endtask

    task automatic test_boundary;
        wr(4'd9, 32'd1000);
        wr(4'd10, 32'd50);
        wr(4'd8, 32'b111);
        wr(4'd9, 32'd10);
        total++; if (timer_irq[2] !== 1'b0) begin bad++; $display("FAIL lower_limit_pre: irq2=%b want 0", timer_irq[2]); end
        @(negedge clk);
        total++; if (timer_irq[2] !== 1'b1) begin bad++; $display("FAIL lower_limit_fire: irq2=%b want 1", timer_irq[2]); end
        wr(4'd9, 32'd0);
        for (int k = 0; k < 4; k++) begin
            wr(4'd11, 32'd1);
            total++;
            if (timer_irq[2] !== 1'b1) begin
                bad++;
                $display("FAIL w1c_vs_fire k=%0d: irq2=%b want 1", k, timer_irq[2]);
            end
        end
        rd(4'd10, 32'd0, "limit0_cnt");
        wr(4'd8, 32'd0);
        wr(4'd11, 32'd1);
        total++; if (timer_irq[2] !== 1'b0) begin bad++; $display("FAIL ch2_stop: irq2=%b want 0", timer_irq[2]); end
    endtask

    task automatic test_regs;
        wr(4'd1, 32'd1000);
        wr(4'd0, 32'b011);
        wr(4'd2, 32'h55);
        rd(4'd2, 32'h55, "count_write_wins");
        rd(4'd0, 32'd3, "ctrl_readback");
        wr(4'd12, 32'hFFFF_FFFF);
        rd(4'd12, 32'd0, "oor_ctrl");
        rd(4'd13, 32'd0, "oor_limit");
        rd(4'd14, 32'd0, "oor_count");
        rd(4'd1, 32'd1000, "limit_readback");
        repeat (2) @(negedge clk);
        total++; if (rdata !== 32'd1000) begin bad++; $display("FAIL rdata_hold: got %0d want 1000", rdata); end
        wr(4'd1, 32'd0);
        repeat (2) @(negedge clk);
        total++; if (timer_irq[0] !== 1'b0 || timer_interrupt !== 1'b0) begin bad++; $display("FAIL masked_irq: irq0=%b int=%b want 0 0", timer_irq[0], timer_interrupt); end
        rd(4'd3, 32'd1, "masked_status");
        wr(4'd0, 32'd0);
        wr(4'd3, 32'd1);
    endtask

    task automatic test_reset_mid;
        wr(4'd5, 32'd0);
        wr(4'd4, 32'b101);
        wr(4'd1, 32'd1000);
        wr(4'd2, 32'd5);
        wr(4'd0, 32'b111);
        rd(4'd1, 32'd1000, "pre_reset_limit");
        @(posedge clk);
        #2;
        total++; if (timer_interrupt !== 1'b1 || rdata !== 32'd1000) begin bad++; $display("FAIL pre_reset_state: int=%b rdata=%0d want 1 1000", timer_interrupt, rdata); end
        rst = 1'b1;
        #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL midrst_rdata: got %h want 0", rdata); end
        total++; if (timer_irq !== 3'b000 || timer_interrupt !== 1'b0) begin bad++; $display("FAIL midrst_irq: irq=%b int=%b want 000 0", timer_irq, timer_interrupt); end
        @(negedge clk);
        rst = 1'b0;
        rd(4'd1, 32'd10000, "midrst_limit");
        rd(4'd2, 32'd0, "midrst_count");
        rd(4'd4, 32'd0, "midrst_ctrl1");
        rd(4'd7, 32'd0, "midrst_status1");
    endtask

    task automatic test_prescale;
        int unsigned gap;
        int unsigned wait_cnt;
        wr(4'd5, 32'd1);
        wr(4'd4, 32'b111);
        wait_cnt = 0;
        while (timer_irq[1] !== 1'b1 && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        total++;
        if (timer_irq[1] !== 1'b1) begin
            bad++;
            $display("FAIL prescale_first: irq1=%b after %0d cycles, want 1", timer_irq[1], wait_cnt);
        end
        wr(4'd7, 32'd1);
        gap = 0;
        while (timer_irq[1] !== 1'b1 && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        total++;
        if (gap != 2 * TB_DIV - 1) begin
            bad++;
            $display("FAIL prescale_period: gap=%0d want %0d", gap, 2 * TB_DIV - 1);
        end
        wr(4'd4, 32'd0);
        wr(4'd7, 32'd1);
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_boundary();
        test_regs();
        test_reset_mid();
        test_prescale();
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d reads never answered", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
